// File: rtl/watchdog_win.sv
// Windowed watchdog on the CSR bus: counts wdt_ce ticks, raises a reset request on timeout
// or early kick, with a pretimeout interrupt, configuration lock and latched live-count read.
module watchdog_win #(
   parameter int unsigned CNT_WIDTH   = 16,
   parameter logic [15:0] DFL_TIMEOUT = 16'h0006,
   parameter logic        DFL_EN      = 1'b0,
   parameter logic [7:0]  KICK_MAGIC  = 8'h6B
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] csr_a,
   input  logic [7:0] csr_di,
   input  logic       csr_we,
   output logic [7:0] csr_do,
   input  logic       wdt_ce,
   output logic       wdt_rst,
   output logic       wdt_irq
);

   typedef enum logic [3:0] {
      ADDR_CTRL   = 4'h0,
      ADDR_TO_L   = 4'h1,
      ADDR_TO_H   = 4'h2,
      ADDR_PRE    = 4'h3,
      ADDR_WIN_L  = 4'h4,
      ADDR_WIN_H  = 4'h5,
      ADDR_KICK   = 4'h6,
      ADDR_CNT_L  = 4'h7,
      ADDR_CNT_H  = 4'h8,
      ADDR_STATUS = 4'h9
   } csr_addr_e;

   csr_addr_e addr;

   logic                 en, lock, irq_en, win_en;
   logic [CNT_WIDTH-1:0] timeout, window, elapsed;
   logic [7:0]           pretimeout, shadow;
   logic                 st_to, st_wv, st_pre;

   logic [15:0]          timeout16, window16, elapsed16;
   logic [15:0]          timeout16_wr, window16_wr;
   logic                 wr_cfg, wr_ctrl, kick_valid, kick_clear, violation;
   logic [2:0]           w1c;
   logic [CNT_WIDTH-1:0] t_eff;
   logic [CNT_WIDTH:0]   e_inc, p_ext, t_ext;
   logic                 inc, to_hit, pre_hit;

   assign addr      = csr_addr_e'(csr_a);
   assign timeout16 = 16'(timeout);
   assign window16  = 16'(window);
   assign elapsed16 = 16'(elapsed);

   assign wr_cfg     = csr_we && !lock;
   assign wr_ctrl    = wr_cfg && (addr == ADDR_CTRL);
   assign kick_valid = csr_we && (addr == ADDR_KICK) && (csr_di == KICK_MAGIC);
   assign w1c        = (csr_we && (addr == ADDR_STATUS)) ? csr_di[2:0] : '0;

   // An early kick is a violation and leaves the count running rather than restarting it
   assign violation  = kick_valid && en && win_en && (window != '0) && (elapsed < window);
   assign kick_clear = kick_valid && !violation;

   assign t_eff = (timeout == '0) ? CNT_WIDTH'(1) : timeout;
   assign t_ext = {1'b0, t_eff};
   assign e_inc = {1'b0, elapsed} + (CNT_WIDTH+1)'(1);
   assign p_ext = (CNT_WIDTH+1)'(pretimeout);

   assign inc     = en && wdt_ce && !wdt_rst && (elapsed != '1) && !kick_clear;
   assign to_hit  = inc && (e_inc == t_ext);
   assign pre_hit = inc && (pretimeout != '0) && (p_ext < t_ext) && ((e_inc + p_ext) == t_ext);

   // 16-bit staging so byte-lane writes work for any CNT_WIDTH in 8..16
   always_comb begin
      timeout16_wr = timeout16;
      window16_wr  = window16;
      if (wr_cfg && (addr == ADDR_TO_L))  timeout16_wr[7:0]  = csr_di;
      if (wr_cfg && (addr == ADDR_TO_H))  timeout16_wr[15:8] = csr_di;
      if (wr_cfg && (addr == ADDR_WIN_L)) window16_wr[7:0]   = csr_di;
      if (wr_cfg && (addr == ADDR_WIN_H)) window16_wr[15:8]  = csr_di;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en         <= DFL_EN;
         lock       <= 1'b0;
         irq_en     <= 1'b0;
         win_en     <= 1'b0;
         timeout    <= DFL_TIMEOUT[CNT_WIDTH-1:0];
         window     <= '0;
         pretimeout <= '0;
      end else begin
         if (wr_ctrl) begin
            en     <= csr_di[0];
            lock   <= csr_di[1];
            irq_en <= csr_di[2];
            win_en <= csr_di[3];
         end
         timeout <= timeout16_wr[CNT_WIDTH-1:0];
         window  <= window16_wr[CNT_WIDTH-1:0];
         if (wr_cfg && (addr == ADDR_PRE)) pretimeout <= csr_di;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         elapsed <= '0;
      end else if (!en || kick_clear) begin
         elapsed <= '0;
      end else if (inc) begin
         elapsed <= e_inc[CNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_to   <= 1'b0;
         st_wv   <= 1'b0;
         st_pre  <= 1'b0;
         wdt_rst <= 1'b0;
         shadow  <= '0;
      end else begin
         st_to   <= to_hit    || (st_to  && !w1c[0]);
         st_wv   <= violation || (st_wv  && !w1c[1]);
         st_pre  <= pre_hit   || (st_pre && !w1c[2]);
         wdt_rst <= wdt_rst || to_hit || violation;
         if (addr == ADDR_CNT_L) shadow <= elapsed16[15:8];
      end
   end

   assign wdt_irq = st_pre && irq_en;

   always_comb begin
      csr_do = '0;
      case (addr)
         ADDR_CTRL:   csr_do = {4'b0000, win_en, irq_en, lock, en};
         ADDR_TO_L:   csr_do = timeout16[7:0];
         ADDR_TO_H:   csr_do = timeout16[15:8];
         ADDR_PRE:    csr_do = pretimeout;
         ADDR_WIN_L:  csr_do = window16[7:0];
         ADDR_WIN_H:  csr_do = window16[15:8];
         ADDR_CNT_L:  csr_do = elapsed16[7:0];
         ADDR_CNT_H:  csr_do = shadow;
         ADDR_STATUS: csr_do = {5'b00000, st_pre, st_wv, st_to};
         default:     csr_do = '0;
      endcase
   end

endmodule

// File: tb/tb_watchdog_win.sv
// Bench for watchdog_win: directed scenarios plus random CSR/tick traffic against a rule-level model.
module tb_watchdog_win;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] csr_a = 4'hF;
   logic [7:0] csr_di = 8'h00;
   logic       csr_we = 1'b0;
   logic       wdt_ce = 1'b0;
   logic [7:0] csr_do;
   logic       wdt_rst;
   logic       wdt_irq;

   int checks = 0;
   int errors = 0;

   watchdog_win #(
      .CNT_WIDTH(16),
      .DFL_TIMEOUT(16'h0006),
      .DFL_EN(1'b0),
      .KICK_MAGIC(8'h6B)
   ) dut (
      .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
      .csr_do(csr_do), .wdt_ce(wdt_ce), .wdt_rst(wdt_rst), .wdt_irq(wdt_irq)
   );

   always #5 clk = ~clk;

   // Reference state, expressed as plain integers and flags
   bit m_valid = 1'b0;
   bit m_en, m_lock, m_irq_en, m_win_en;
   bit m_to, m_wv, m_pre, m_rst;
   int m_timeout, m_ptime, m_window, m_el, m_shadow;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [3:0] a);
      case (a)
         4'h0: return {4'b0000, m_win_en, m_irq_en, m_lock, m_en};
         4'h1: return 8'(m_timeout);
         4'h2: return 8'(m_timeout >> 8);
         4'h3: return 8'(m_ptime);
         4'h4: return 8'(m_window);
         4'h5: return 8'(m_window >> 8);
         4'h7: return 8'(m_el);
         4'h8: return 8'(m_shadow);
         4'h9: return {5'b00000, m_pre, m_wv, m_to};
         default: return 8'h00;
      endcase
   endfunction

   task automatic m_step(input bit r, input bit w, input logic [3:0] a, input logic [7:0] d, input bit ce);
      int  t;
      bit  kick, viol, kclr, inc, set_to, set_pre;
      logic [7:0] clr;
      if (r) begin
         m_valid = 1'b1;
         m_en = 1'b0; m_lock = 1'b0; m_irq_en = 1'b0; m_win_en = 1'b0;
         m_to = 1'b0; m_wv = 1'b0; m_pre = 1'b0; m_rst = 1'b0;
         m_timeout = 6; m_ptime = 0; m_window = 0; m_el = 0; m_shadow = 0;
         return;
      end
      if (!m_valid) return;
      t       = (m_timeout == 0) ? 1 : m_timeout;
      kick    = w && (a == 4'h6) && (d == 8'h6B);
      viol    = kick && m_en && m_win_en && (m_window != 0) && (m_el < m_window);
      kclr    = kick && !viol;
      inc     = m_en && ce && !m_rst && (m_el < 65535) && !kclr;
      set_to  = inc && (m_el + 1 == t);
      set_pre = inc && (m_ptime != 0) && (m_ptime < t) && (t - (m_el + 1) == m_ptime);
      clr     = (w && (a == 4'h9)) ? d : 8'h00;
      if (a == 4'h7) m_shadow = m_el >> 8;
      if (!m_en || kclr) m_el = 0;
      else if (inc) m_el = m_el + 1;
      m_to  = set_to  || (m_to  && !clr[0]);
      m_wv  = viol    || (m_wv  && !clr[1]);
      m_pre = set_pre || (m_pre && !clr[2]);
      m_rst = m_rst || set_to || viol;
      if (w && !m_lock) begin
         case (a)
            4'h0: begin m_en = d[0]; m_lock = d[1]; m_irq_en = d[2]; m_win_en = d[3]; end
            4'h1: m_timeout = (m_timeout & 32'hFF00) | int'(d);
            4'h2: m_timeout = (m_timeout & 32'h00FF) | (int'(d) << 8);
            4'h3: m_ptime = int'(d);
            4'h4: m_window = (m_window & 32'hFF00) | int'(d);
            4'h5: m_window = (m_window & 32'h00FF) | (int'(d) << 8);
            default: ;
         endcase
      end
   endtask

   task automatic cyc(input bit r, input bit w, input logic [3:0] a, input logic [7:0] d, input bit ce,
                      input string tag = "", input bit has_exp = 1'b0, input logic [7:0] exp = 8'h00);
      @(negedge clk);
      rst = r; csr_we = w; csr_a = a; csr_di = d; wdt_ce = ce;
      #1;
      if (m_valid) begin
         chk("csr_do_model", csr_do, m_read(a));
         chk("wdt_rst_model", {7'b0, wdt_rst}, {7'b0, m_rst});
         chk("wdt_irq_model", {7'b0, wdt_irq}, {7'b0, m_pre && m_irq_en});
      end
      if (has_exp) chk(tag, csr_do, exp);
      @(posedge clk);
      m_step(r, w, a, d, ce);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      cyc(1'b0, 1'b1, a, d, 1'b0);
   endtask

   task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
      cyc(1'b0, 1'b0, a, 8'h00, 1'b0, tag, 1'b1, exp);
   endtask

   task automatic tick();
      cyc(1'b0, 1'b0, 4'hF, 8'h00, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 4'hF, 8'h00, 1'b0);
   endtask

   task automatic do_rst();
      cyc(1'b1, 1'b0, 4'hF, 8'h00, 1'b0);
   endtask

   initial begin
      bit         r_r, r_w, r_ce;
      logic [3:0] r_a;
      logic [7:0] r_d;
      int         sel;

      // Reset state
      do_rst();
      #1 chk("rst_wdt_rst", {7'b0, wdt_rst}, 8'h00);
      rd(4'h0, 8'h00, "rst_ctrl");
      rd(4'h1, 8'h06, "rst_timeout_l");
      rd(4'h9, 8'h00, "rst_status");

      // Enable with no kicks: timeout on the sixth tick, sticky through a kick
      wr(4'h0, 8'h01);
      for (int i = 1; i <= 6; i++) begin
         idle(31);
         tick();
         #1 chk("noKick_rst_tick", {7'b0, wdt_rst}, (i == 6) ? 8'h01 : 8'h00);
      end
      rd(4'h9, 8'h01, "noKick_status");
      wr(4'h6, 8'h6B);
      #1 chk("noKick_rst_sticky", {7'b0, wdt_rst}, 8'h01);
      do_rst();
      #1 chk("noKick_rst_cleared", {7'b0, wdt_rst}, 8'h00);

      // Regular kicks keep it alive; a wrong magic does not
      wr(4'h0, 8'h01);
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i % 4 == 0) wr(4'h6, 8'h6B);
      end
      #1 chk("kick_alive", {7'b0, wdt_rst}, 8'h00);
      do_rst();
      wr(4'h0, 8'h01);
      repeat (4) tick();
      wr(4'h6, 8'h55);
      tick();
      #1 chk("badKick_tick5", {7'b0, wdt_rst}, 8'h00);
      tick();
      #1 chk("badKick_tick6", {7'b0, wdt_rst}, 8'h01);

      // Pretimeout interrupt
      do_rst();
      wr(4'h3, 8'h02);
      wr(4'h0, 8'h05);
      for (int i = 1; i <= 4; i++) begin
         tick();
         #1 chk("pre_irq_tick", {7'b0, wdt_irq}, (i == 4) ? 8'h01 : 8'h00);
      end
      wr(4'h9, 8'h04);
      #1 chk("pre_irq_cleared", {7'b0, wdt_irq}, 8'h00);
      tick();
      tick();
      #1 chk("pre_rst_tick6", {7'b0, wdt_rst}, 8'h01);

      // Window violation, then a legal kick past the window
      do_rst();
      wr(4'h4, 8'h03);
      wr(4'h1, 8'h08);
      wr(4'h0, 8'h09);
      tick();
      wr(4'h6, 8'h6B);
      #1 chk("win_viol_rst", {7'b0, wdt_rst}, 8'h01);
      rd(4'h9, 8'h02, "win_viol_status");
      do_rst();
      wr(4'h4, 8'h03);
      wr(4'h1, 8'h08);
      wr(4'h0, 8'h09);
      repeat (4) tick();
      wr(4'h6, 8'h6B);
      #1 chk("win_ok_rst", {7'b0, wdt_rst}, 8'h00);
      rd(4'h7, 8'h00, "win_ok_elapsed");
      rd(4'h9, 8'h00, "win_ok_status");

      // Lock
      do_rst();
      wr(4'h0, 8'h03);
      wr(4'h1, 8'h20);
      rd(4'h1, 8'h06, "lock_timeout");
      wr(4'h0, 8'h00);
      rd(4'h0, 8'h03, "lock_ctrl");

      // Live count read through the shadow, then kick colliding with a tick
      do_rst();
      wr(4'h1, 8'hFF);
      wr(4'h2, 8'hFF);
      wr(4'h0, 8'h01);
      repeat (261) tick();
      rd(4'h7, 8'h05, "count_l");
      rd(4'h8, 8'h01, "count_h");
      cyc(1'b0, 1'b1, 4'h6, 8'h6B, 1'b1);
      rd(4'h7, 8'h00, "kick_tick_elapsed");
      rd(4'h8, 8'h00, "kick_tick_shadow");

      // Random traffic against the model
      do_rst();
      for (int n = 0; n < 4000; n++) begin
         r_r  = (n % 500 == 499) || ($urandom_range(0, 299) == 0);
         r_w  = ($urandom_range(0, 2) == 0);
         r_ce = ($urandom_range(0, 2) == 0);
         sel  = int'($urandom_range(0, 9));
         case (sel)
            0, 1, 2: begin
               r_a = 4'h6;
               r_d = ($urandom_range(0, 4) != 0) ? 8'h6B : 8'($urandom);
            end
            3: begin r_a = 4'h9; r_d = 8'($urandom); end
            4: begin
               r_a = 4'h0;
               r_d = 8'($urandom) & (($urandom_range(0, 7) == 0) ? 8'hFF : 8'hFD);
            end
            5: begin r_a = 4'h1; r_d = 8'($urandom_range(0, 15)); end
            6: begin r_a = 4'h3; r_d = 8'($urandom_range(0, 6)); end
            7: begin r_a = 4'h4; r_d = 8'($urandom_range(0, 8)); end
            default: begin
               r_a = 4'($urandom);
               r_d = (r_a == 4'h2 || r_a == 4'h5) ? 8'h00 : 8'($urandom);
            end
         endcase
         cyc(r_r, r_w, r_a, r_d, r_ce);
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
